// File: rtl/seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// seq_det_ctrl
//
// Frame-level controller for the serial pattern-detection path.
//
// A frame is started with Start (carrying Frame_Len, the number of words).
// Each word is taken through an In_Valid/In_Ready handshake and then shifted
// out MSB-first on Ser_Bit/Ser_Valid, one bit per cycle. Every serialized bit
// is pushed into a history register. The history is compared against a
// programmable pattern of 2..8 bits, and overlapping hits are counted. The
// history carries across word boundaries and is cleared only at Start.
//
// Ports
//   Clk        : clock
//   Reset      : asynchronous, active-high reset (aborts any frame in flight)
//   Cfg_We     : pattern write strobe (accepted in IDLE only, else Err pulse)
//   Cfg_Pat    : pattern, LSB = most recent bit, low Len bits used
//   Cfg_Len    : pattern length, clamped into 2..8 when stored
//   Start      : start-of-frame pulse (accepted in IDLE only)
//   Frame_Len  : words in the frame, sampled with Start
//   In_Valid   : input word valid
//   In_Data    : input word
//   In_Ready   : controller can take a word (WAIT state)
//   Ser_Bit    : serialized bit (0 when Ser_Valid is low)
//   Ser_Valid  : Ser_Bit valid (SHIFT state)
//   Match      : one-cycle pulse, the cycle after the bit that completed a hit
//   Match_Cnt  : saturating hit count for the current/last frame
//   Busy       : high in every state except IDLE
//   Done       : one-cycle frame-complete pulse
//   Err        : one-cycle pulse after a rejected Cfg_We
// -----------------------------------------------------------------------------
module seq_det_ctrl #(
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Cfg_We,
  input  logic [7:0]    Cfg_Pat,
  input  logic [3:0]    Cfg_Len,
  input  logic          Start,
  input  logic [7:0]    Frame_Len,
  input  logic          In_Valid,
  input  logic [DW-1:0] In_Data,
  output logic          In_Ready,
  output logic          Ser_Bit,
  output logic          Ser_Valid,
  output logic          Match,
  output logic [CW-1:0] Match_Cnt,
  output logic          Busy,
  output logic          Done,
  output logic          Err
);

  localparam int IW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [7:0]    pat_q,   pat_d;
  logic [3:0]    len_q,   len_d;
  logic [7:0]    words_q, words_d;   // words still to be accepted
  logic [DW-1:0] word_q,  word_d;    // word being serialized
  logic [IW-1:0] idx_q,   idx_d;     // bit index of the word, counts down
  logic [6:0]    hist_q,  hist_d;    // only 7 older bits are needed, the 8th is the live bit
  logic [3:0]    fill_q,  fill_d;    // bits seen this frame, saturates at 8
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          match_q, match_d;
  logic          err_q,   err_d;

  // ---------------------------------------------------------------------------
  // Match datapath
  // ---------------------------------------------------------------------------
  logic       cur_bit;
  logic [7:0] window;
  logic [3:0] fill_inc;
  logic [7:0] len_mask;
  logic       hit;

  function automatic logic [3:0] clamp_len(input logic [3:0] l);
    if (l < 4'd2) begin
      return 4'd2;
    end else if (l > 4'd8) begin
      return 4'd8;
    end else begin
      return l;
    end
  endfunction

  assign cur_bit  = word_q[idx_q];
  // Window includes the bit on the wire this cycle, so a hit is known in the
  // same cycle and registered into Match on the following edge.
  assign window   = {hist_q, cur_bit};
  assign fill_inc = (fill_q == 4'd8) ? 4'd8 : fill_q + 4'd1;

  // Thermometer mask selecting the low len_q bits of the window/pattern.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_mask
      assign len_mask[gi] = (4'(gi) < len_q);
    end
  endgenerate

  // A hit also needs enough bits since Start, so zeros left in the cleared
  // history can never complete a pattern.
  assign hit = (fill_inc >= len_q) && (((window ^ pat_q) & len_mask) == 8'd0);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    words_d = words_q;
    word_d  = word_q;
    idx_d   = idx_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    match_d = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A write and a Start in the same cycle both land. The frame uses the
        // new pattern because matching reads pat_q only in SHIFT.
        if (Cfg_We) begin
          pat_d = Cfg_Pat;
          len_d = clamp_len(Cfg_Len);
        end
        if (Start) begin
          words_d = Frame_Len;
          cnt_d   = '0;
          hist_d  = '0;
          fill_d  = '0;
          state_d = (Frame_Len != 8'd0) ? S_WAIT : S_DONE;
        end
      end

      S_WAIT: begin
        if (In_Valid) begin
          word_d  = In_Data;
          idx_d   = IW'(DW - 1);
          words_d = words_q - 8'd1;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        hist_d = window[6:0];
        fill_d = fill_inc;
        if (hit) begin
          match_d = 1'b1;
          if (cnt_q != {CW{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (idx_q == '0) begin
          state_d = (words_q != 8'd0) ? S_WAIT : S_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Writes are refused while a frame is in progress. This includes the DONE
    // cycle, so the pattern can never change under a running frame.
    if (Cfg_We && (state_q != S_IDLE)) begin
      err_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pat_q   <= 8'b0000_0110;
      len_q   <= 4'd4;
      words_q <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      words_q <= words_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign In_Ready  = (state_q == S_WAIT);
  assign Ser_Valid = (state_q == S_SHIFT);
  assign Ser_Bit   = Ser_Valid & cur_bit;
  assign Busy      = (state_q != S_IDLE);
  assign Done      = (state_q == S_DONE);
  assign Match     = match_q;
  assign Match_Cnt = cnt_q;
  assign Err       = err_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_det_ctrl
//
// Testbench for seq_det_ctrl. A transaction-level model tracks the following:
//   - the queue of bits still to be serialized
//   - the last 8 bits of the frame's bit stream
//   - the pattern and length
// Expected outputs are derived from this model and compared with the DUT
// outputs every cycle. Directed frames also check hand-computed results.
// -----------------------------------------------------------------------------
module tb_seq_det_ctrl;

  localparam int DW = 8;
  localparam int CW = 8;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Cfg_We;
  logic [7:0]    Cfg_Pat;
  logic [3:0]    Cfg_Len;
  logic          Start;
  logic [7:0]    Frame_Len;
  logic          In_Valid;
  logic [DW-1:0] In_Data;
  logic          In_Ready;
  logic          Ser_Bit;
  logic          Ser_Valid;
  logic          Match;
  logic [CW-1:0] Match_Cnt;
  logic          Busy;
  logic          Done;
  logic          Err;

  seq_det_ctrl #(.DW(DW), .CW(CW)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Cfg_We    (Cfg_We),
    .Cfg_Pat   (Cfg_Pat),
    .Cfg_Len   (Cfg_Len),
    .Start     (Start),
    .Frame_Len (Frame_Len),
    .In_Valid  (In_Valid),
    .In_Data   (In_Data),
    .In_Ready  (In_Ready),
    .Ser_Bit   (Ser_Bit),
    .Ser_Valid (Ser_Valid),
    .Match     (Match),
    .Match_Cnt (Match_Cnt),
    .Busy      (Busy),
    .Done      (Done),
    .Err       (Err)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (transaction level)
  // ---------------------------------------------------------------------------
  bit         m_active;      // a frame is in progress (Busy)
  bit         m_done;        // this cycle is the completion cycle
  bit         sq[$];         // bits still to be serialized
  bit         hist[$];       // last bits of the frame stream, oldest first
  int         words_left;
  logic [7:0] m_pat;
  int         m_len;
  int         m_cnt;
  bit         m_match;
  bit         m_err;
  bit         nm;
  bit         ne;
  bit         b;
  bit         eq;

  // DUT event tallies, for directed checks
  int match_pulses = 0;
  int err_pulses   = 0;
  int done_pulses  = 0;
  int sv_cycles    = 0;

  function automatic int clamp(input int l);
    return (l < 2) ? 2 : ((l > 8) ? 8 : l);
  endfunction

  task automatic model_reset();
    m_active   = 0;
    m_done     = 0;
    sq.delete();
    hist.delete();
    words_left = 0;
    m_pat      = 8'h06;
    m_len      = 4;
    m_cnt      = 0;
    m_match    = 0;
    m_err      = 0;
  endtask

  initial begin : model_and_compare
    model_reset();
    forever begin
      @(posedge Clk or posedge Reset);
      if (Reset) begin
        model_reset();
      end else begin
        // Advance the model using the inputs present at this clock edge
        nm = 0;
        ne = Cfg_We && m_active;
        if (m_done) begin
          m_done   = 0;
          m_active = 0;
        end else if (!m_active) begin
          if (Cfg_We) begin
            m_pat = Cfg_Pat;
            m_len = clamp(int'(Cfg_Len));
          end
          if (Start) begin
            m_active   = 1;
            m_cnt      = 0;
            hist.delete();
            words_left = int'(Frame_Len);
            if (words_left == 0) m_done = 1;
          end
        end else if (sq.size() > 0) begin
          b = sq.pop_front();
          hist.push_back(b);
          if (hist.size() > 8) void'(hist.pop_front());
          if (hist.size() >= m_len) begin
            eq = 1;
            for (int k = 0; k < m_len; k++)
              if (hist[hist.size() - 1 - k] != m_pat[k]) eq = 0;
            if (eq) begin
              nm = 1;
              if (m_cnt < (1 << CW) - 1) m_cnt++;
            end
          end
          if (sq.size() == 0 && words_left == 0) m_done = 1;
        end else if (In_Valid) begin
          for (int i = DW - 1; i >= 0; i--) sq.push_back(In_Data[i]);
          words_left--;
        end
        m_match = nm;
        m_err   = ne;

        #1;
        if (!Reset) begin
          chk("in_ready",  int'(In_Ready),
              int'(m_active && !m_done && sq.size() == 0 && words_left > 0));
          chk("ser_valid", int'(Ser_Valid), int'(sq.size() > 0));
          chk("ser_bit",   int'(Ser_Bit),   (sq.size() > 0) ? int'(sq[0]) : 0);
          chk("match",     int'(Match),     int'(m_match));
          chk("match_cnt", int'(Match_Cnt), m_cnt);
          chk("busy",      int'(Busy),      int'(m_active));
          chk("done",      int'(Done),      int'(m_done));
          chk("err",       int'(Err),       int'(m_err));
          match_pulses += int'(Match);
          err_pulses   += int'(Err);
          done_pulses  += int'(Done);
          sv_cycles    += int'(Ser_Valid);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers (all called at a negedge)
  // ---------------------------------------------------------------------------
  logic [7:0] words [16];

  task automatic pulse_cfg(input logic [7:0] p, input logic [3:0] l);
    Cfg_We  = 1'b1;
    Cfg_Pat = p;
    Cfg_Len = l;
    @(negedge Clk);
    Cfg_We  = 1'b0;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!In_Ready && k < 100) begin
      @(negedge Clk);
      k++;
    end
    chk("ready_seen", int'(In_Ready), 1);
  endtask

  // Runs one frame. inject=1 writes the config once during the first word's
  // SHIFT. noise=1 scatters ignored Start and rejected Cfg_We pulses while busy.
  task automatic run_frame(input int n, input bit inject, input bit noise,
                           output int pulses, output int cnt_done,
                           output int match_done, output int errs,
                           output int svc, output int done_wait);
    int m0 = match_pulses;
    int e0 = err_pulses;
    int s0 = sv_cycles;
    int k  = 0;
    Start     = 1'b1;
    Frame_Len = 8'(n);
    @(negedge Clk);
    Start = 1'b0;
    for (int w = 0; w < n; w++) begin
      repeat ($urandom_range(0, 2)) @(negedge Clk);
      wait_ready();
      In_Valid = 1'b1;
      In_Data  = words[w];
      @(negedge Clk);
      In_Valid = 1'b0;
      In_Data  = DW'($urandom);
      if (inject && w == 0) begin
        repeat (2) @(negedge Clk);
        pulse_cfg(8'hFF, 4'd8);
      end
    end
    while (!Done && k < 200) begin
      if (noise) begin
        Start   = ($urandom_range(0, 7) == 0);
        Cfg_We  = ($urandom_range(0, 15) == 0);
        Cfg_Pat = 8'($urandom);
      end
      @(negedge Clk);
      k++;
    end
    Start  = 1'b0;
    Cfg_We = 1'b0;
    chk("done_seen", int'(Done), 1);
    done_wait  = k;
    cnt_done   = int'(Match_Cnt);
    match_done = int'(Match);
    @(negedge Clk);
    pulses = match_pulses - m0;
    errs   = err_pulses - e0;
    svc    = sv_cycles - s0;
    $display("frame n=%0d pulses=%0d cnt=%0d errs=%0d ser_cycles=%0d",
             n, pulses, cnt_done, errs, svc);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"},  int'(In_Ready),  0);
    chk({tag, "_ser_valid"}, int'(Ser_Valid), 0);
    chk({tag, "_ser_bit"},   int'(Ser_Bit),   0);
    chk({tag, "_match"},     int'(Match),     0);
    chk({tag, "_match_cnt"}, int'(Match_Cnt), 0);
    chk({tag, "_busy"},      int'(Busy),      0);
    chk({tag, "_done"},      int'(Done),      0);
    chk({tag, "_err"},       int'(Err),       0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stim
    int p, c, md, e, s, dw, d0;
    Reset     = 1'b1;
    Cfg_We    = 1'b0;
    Cfg_Pat   = 8'h00;
    Cfg_Len   = 4'd0;
    Start     = 1'b0;
    Frame_Len = 8'd0;
    In_Valid  = 1'b0;
    In_Data   = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    #1 chk_all_zero("reset");
    @(negedge Clk);

    // Default pattern 0110 on 0x36: hits after bits 5 and 8
    words[0] = 8'h36;
    run_frame(1, 0, 0, p, c, md, e, s, dw);
    chk("t1_pulses", p, 2);
    chk("t1_cnt", c, 2);
    chk("t1_match_at_done", md, 1);
    chk("t1_ser_cycles", s, 8);

    // Pattern 1110: the single hit spans the word boundary
    pulse_cfg(8'h0E, 4'd4);
    words[0] = 8'h01;
    words[1] = 8'hC0;
    run_frame(2, 0, 0, p, c, md, e, s, dw);
    chk("t2_pulses", p, 1);
    chk("t2_cnt", c, 1);
    chk("t2_ser_cycles", s, 16);

    // Empty frame: Done the cycle after Start, no serialization
    run_frame(0, 0, 0, p, c, md, e, s, dw);
    chk("t3_done_wait", dw, 0);
    chk("t3_cnt", c, 0);
    chk("t3_ser_cycles", s, 0);
    chk("t3_busy_after", int'(Busy), 0);

    // Length 0 clamps to 2: pattern 11 on 0xFF gives 7 overlapping hits
    pulse_cfg(8'h03, 4'd0);
    words[0] = 8'hFF;
    run_frame(1, 0, 0, p, c, md, e, s, dw);
    chk("t4_pulses", p, 7);
    chk("t4_cnt", c, 7);

    // Rejected write mid-frame: Err once, result same as undisturbed (11 on 0x36)
    words[0] = 8'h36;
    run_frame(1, 1, 0, p, c, md, e, s, dw);
    chk("t5_err_pulses", e, 1);
    chk("t5_cnt", c, 2);
    run_frame(1, 0, 0, p, c, md, e, s, dw);
    chk("t5_pattern_kept", c, 2);

    // Reset in the 4th SHIFT cycle of a 3-word frame
    pulse_cfg(8'h0F, 4'd3);
    d0        = done_pulses;
    Start     = 1'b1;
    Frame_Len = 8'd3;
    @(negedge Clk);
    Start = 1'b0;
    wait_ready();
    In_Valid = 1'b1;
    In_Data  = 8'hA5;
    @(negedge Clk);
    In_Valid = 1'b0;
    repeat (3) @(negedge Clk);
    chk("t6_in_shift", int'(Ser_Valid), 1);
    #1 Reset = 1'b1;
    #1 chk_all_zero("t6");
    @(negedge Clk);
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
    chk("t6_no_done", done_pulses - d0, 0);
    words[0] = 8'h36;
    run_frame(1, 0, 0, p, c, md, e, s, dw);
    chk("t6_default_restored", c, 2);

    // Randomized frames, checked every cycle by the model
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 1) == 1)
        pulse_cfg(8'($urandom), 4'($urandom_range(0, 15)));
      for (int w = 0; w < 16; w++) words[w] = 8'($urandom);
      run_frame($urandom_range(0, 5), 0, 1, p, c, md, e, s, dw);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
